byte_striping_4lane: RTL and testbench

//   Upstream stage of the 4-lane valid/data flop bank. Accepts a serial byte stream
//   (one byte per clkf cycle when valid_in=1) and distributes consecutive bytes

---
 rtl/byte_striping_4lane.sv | 93 +++++++++
 tb/tb_byte_striping_4lane.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/byte_striping_4lane.sv
// Serial-to-4-lane byte striper: collects bytes round-robin into lanes 0..3 and
// emits one registered word with per-lane valid pulses; flush pads a partial word.
module byte_striping_4lane #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PAD_BYTE = 8'hF7
) (
    input  logic              clkf,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              flush,
    output logic [DATA_W-1:0] lane0_data,
    output logic [DATA_W-1:0] lane1_data,
    output logic [DATA_W-1:0] lane2_data,
    output logic [DATA_W-1:0] lane3_data,
    output logic              valid0,
    output logic              valid1,
    output logic              valid2,
    output logic              valid3,
    output logic [1:0]        lane_ptr
);

    logic [1:0]        r_ptr;
    logic [DATA_W-1:0] r_h    [0:2];
    logic [DATA_W-1:0] r_lane [0:3];
    logic [3:0]        r_valid;

    logic              w_emit;
    logic [2:0]        w_fill;
    logic [DATA_W-1:0] w_lane_next [0:3];
    logic [3:0]        w_valid_next;

    // A word leaves when the 4th byte arrives, or on flush with at least one byte held/arriving.
    assign w_emit = (valid_in && ((r_ptr == 2'd3) || flush)) || (flush && (r_ptr != 2'd0));
    assign w_fill = {1'b0, r_ptr} + {2'b00, valid_in};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_valid_next[gi] = (3'(gi) < w_fill);

            if (gi < 3) begin : g_held
                assign w_lane_next[gi] = (2'(gi) < r_ptr)                  ? r_h[gi] :
                                         ((2'(gi) == r_ptr) && valid_in) ? data_in :
                                                                           PAD_BYTE;

                always_ff @(posedge clkf) begin
                    if (reset) begin
                        r_h[gi] <= '0;
                    end else if (valid_in && !w_emit && (r_ptr == 2'(gi))) begin
                        r_h[gi] <= data_in;
                    end
                end
            end else begin : g_last
                // Lane 3 can only be filled directly from the incoming byte.
                assign w_lane_next[gi] = ((r_ptr == 2'd3) && valid_in) ? data_in : PAD_BYTE;
            end

            always_ff @(posedge clkf) begin
                if (reset) begin
                    r_lane[gi] <= '0;
                end else if (w_emit) begin
                    r_lane[gi] <= w_lane_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clkf) begin
        if (reset) begin
            r_ptr   <= 2'd0;
            r_valid <= 4'b0000;
        end else begin
            r_valid <= w_emit ? w_valid_next : 4'b0000;
            if (w_emit) begin
                r_ptr <= 2'd0;
            end else if (valid_in) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign lane0_data = r_lane[0];
    assign lane1_data = r_lane[1];
    assign lane2_data = r_lane[2];
    assign lane3_data = r_lane[3];
    assign valid0     = r_valid[0];
    assign valid1     = r_valid[1];
    assign valid2     = r_valid[2];
    assign valid3     = r_valid[3];
    assign lane_ptr   = r_ptr;

endmodule

// File: tb/tb_byte_striping_4lane.sv
// Bench for byte_striping_4lane: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the byte stream.
module tb_byte_striping_4lane;

    localparam logic [7:0] PAD = 8'hF7;

    logic       clkf = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       flush;
    logic [7:0] lane0_data, lane1_data, lane2_data, lane3_data;
    logic       valid0, valid1, valid2, valid3;
    logic [1:0] lane_ptr;

    byte_striping_4lane dut (
        .clkf       (clkf),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .flush      (flush),
        .lane0_data (lane0_data),
        .lane1_data (lane1_data),
        .lane2_data (lane2_data),
        .lane3_data (lane3_data),
        .valid0     (valid0),
        .valid1     (valid1),
        .valid2     (valid2),
        .valid3     (valid3),
        .lane_ptr   (lane_ptr)
    );

    always #5 clkf = ~clkf;

    int         n_cmp = 0;
    int         n_err = 0;
    int         pulses = 0;
    logic [7:0] pend [$];
    logic [7:0] exp_lane [4];
    logic [3:0] exp_valid;

    // Reference: bytes accumulate in a queue; a word is emitted once 4 bytes are
    // queued, or on flush when anything is queued, with padding behind the bytes.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic f, input logic r);
        int n;
        if (r) begin
            pend.delete();
            for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
            exp_valid = 4'b0000;
            return;
        end
        exp_valid = 4'b0000;
        if (v) pend.push_back(d);
        n = pend.size();
        if (n == 4 || (f && n > 0)) begin
            for (int i = 0; i < 4; i++) exp_lane[i] = (i < n) ? pend[i] : PAD;
            exp_valid = 4'((1 << n) - 1);
            pend.delete();
        end
    endtask

    task automatic check(input string tag);
        logic [31:0] act_l, exp_l;
        logic [3:0]  act_v;
        logic [1:0]  exp_p;
        act_l = {lane3_data, lane2_data, lane1_data, lane0_data};
        exp_l = {exp_lane[3], exp_lane[2], exp_lane[1], exp_lane[0]};
        act_v = {valid3, valid2, valid1, valid0};
        exp_p = 2'(pend.size());
        n_cmp++;
        assert (act_l === exp_l) else begin
            n_err++;
            $error("FAIL %s lanes(3..0): got %h expected %h", tag, act_l, exp_l);
        end
        n_cmp++;
        assert (act_v === exp_valid) else begin
            n_err++;
            $error("FAIL %s valid(3..0): got %b expected %b", tag, act_v, exp_valid);
        end
        n_cmp++;
        assert (lane_ptr === exp_p) else begin
            n_err++;
            $error("FAIL %s lane_ptr: got %0d expected %0d", tag, lane_ptr, exp_p);
        end
        if (valid0 === 1'b1) pulses++;
        $display("%s: v=%b d=%h f=%b r=%b -> lanes=%h valid=%b ptr=%0d", tag, valid_in, data_in,
                 flush, reset, act_l, act_v, lane_ptr);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r,
                        input string tag);
        valid_in = v;
        data_in  = d;
        flush    = f;
        reset    = r;
        @(posedge clkf);
        model_edge(v, d, f, r);
        #1;
        check(tag);
    endtask

    initial begin
        int gaps;
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; data_in = 8'h00;
        exp_valid = 4'b0000;
        for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;

        step(0, 8'h00, 0, 1, "reset0");
        step(0, 8'h00, 0, 1, "reset1");

        step(1, 8'h11, 0, 0, "word_b0");
        step(1, 8'h22, 0, 0, "word_b1");
        step(1, 8'h33, 0, 0, "word_b2");
        step(1, 8'h44, 0, 0, "word_b3");
        step(0, 8'h00, 0, 0, "word_idle");

        step(1, 8'hA1, 0, 0, "flush2_b0");
        step(1, 8'hA2, 0, 0, "flush2_b1");
        step(0, 8'h00, 1, 0, "flush2_f");
        step(0, 8'h00, 0, 0, "flush2_idle");
        step(0, 8'h00, 1, 0, "flush_empty");

        step(1, 8'hB1, 0, 0, "flush3_b0");
        step(1, 8'hB2, 0, 0, "flush3_b1");
        step(1, 8'hB3, 1, 0, "flush3_bf");
        step(1, 8'hC0, 1, 0, "flush1_bf");
        step(0, 8'h00, 0, 0, "flush1_idle");

        pulses = 0;
        for (int b = 1; b <= 12; b++) begin
            step(1, 8'(b), 0, 0, "gaps_byte");
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) step(0, 8'h5A, 0, 0, "gaps_idle");
        end
        step(0, 8'h00, 0, 0, "gaps_tail");
        n_cmp++;
        assert (pulses == 3) else begin
            n_err++;
            $error("FAIL gaps_pulses: got %0d expected 3", pulses);
        end

        step(1, 8'hC1, 0, 0, "rst_c1");
        step(1, 8'hC2, 0, 0, "rst_c2");
        step(1, 8'hCC, 1, 1, "rst_prio");
        step(1, 8'hD1, 0, 0, "rst_d1");
        step(1, 8'hD2, 0, 0, "rst_d2");
        step(1, 8'hD3, 0, 0, "rst_d3");
        step(1, 8'hD4, 0, 0, "rst_d4");
        step(0, 8'h00, 0, 0, "rst_idle");

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
